// File: rtl/fft_adc_loader_if.sv
// Sample-loader bus: ADC stream and FFT handshake in, FFT input-RAM write port out.
// The ADC/bench side drives through master; the loader attaches through slave.
interface fft_adc_loader_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned BANK_AW = 9
);
    logic                iENABLE;
    logic [DATA_W-1:0]   iSAMPLE;
    logic                iVALID;
    logic                iFFT_RDY;
    logic [DATA_W-1:0]   oDATA;
    logic [BANK_AW-1:0]  oADDR_WR_0;
    logic [BANK_AW-1:0]  oADDR_WR_1;
    logic [BANK_AW-1:0]  oADDR_WR_2;
    logic [BANK_AW-1:0]  oADDR_WR_3;
    logic                oWE_0;
    logic                oWE_1;
    logic                oWE_2;
    logic                oWE_3;
    logic                oSTART;
    logic                oBUSY;
    logic                oFRAME_DONE;
    logic [15:0]         oDROP_CNT;

    modport master (
        output iENABLE, iSAMPLE, iVALID, iFFT_RDY,
        input  oDATA, oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
               oWE_0, oWE_1, oWE_2, oWE_3, oSTART, oBUSY, oFRAME_DONE, oDROP_CNT
    );

    modport slave (
        input  iENABLE, iSAMPLE, iVALID, iFFT_RDY,
        output oDATA, oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
               oWE_0, oWE_1, oWE_2, oWE_3, oSTART, oBUSY, oFRAME_DONE, oDROP_CNT
    );
endinterface

// File: rtl/fft_adc_loader.sv
// Loads one 2048-sample frame of ADC data into the four FFT input banks,
// strobes the FFT start and holds off new frames until the FFT reports done.
module fft_adc_loader #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned BANK_AW = 9,
    parameter int unsigned N_BANK  = 4
) (
    input  logic           iCLK,
    input  logic           iRESET,
    fft_adc_loader_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(N_BANK);
    localparam int unsigned IDX_W = BANK_AW + SEL_W;
    localparam int unsigned CNT_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_START, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   n_q, n_d;
    logic               rdy_q, rdy_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [BANK_AW-1:0] addr_q [N_BANK];
    logic [BANK_AW-1:0] addr_d [N_BANK];
    logic [N_BANK-1:0]  we_q, we_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               rdy_rise;
    logic               drop_inc;
    logic [SEL_W-1:0]   sel;

    // Next-state, write path and drop counting
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        rdy_d    = bus.iFFT_RDY;
        data_d   = data_q;
        addr_d   = addr_q;
        we_d     = '0;
        start_d  = 1'b0;
        done_d   = 1'b0;
        drop_d   = drop_q;
        drop_inc = 1'b0;
        rdy_rise = bus.iFFT_RDY & ~rdy_q;
        sel      = n_q[IDX_W-1:BANK_AW];

        case (state_q)
            S_IDLE: begin
                if (bus.iENABLE) begin
                    state_d = S_FILL;
                    n_d     = '0;
                end
            end
            S_FILL: begin
                if (!bus.iENABLE) begin
                    state_d = S_IDLE;
                    n_d     = '0;
                end else if (bus.iVALID) begin
                    data_d      = bus.iSAMPLE;
                    we_d[sel]   = 1'b1;
                    addr_d[sel] = n_q[BANK_AW-1:0];
                    n_d         = n_q + IDX_W'(1);
                    if (n_q == LAST_IDX) begin
                        state_d = S_START;
                        start_d = 1'b1;
                    end
                end
            end
            S_START: begin
                drop_inc = bus.iVALID;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                drop_inc = bus.iVALID;
                if (rdy_rise) begin
                    done_d  = 1'b1;
                    n_d     = '0;
                    state_d = bus.iENABLE ? S_FILL : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (drop_inc && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
        busy_d = (state_d == S_START) || (state_d == S_WAIT);
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            rdy_q   <= 1'b0;
            data_q  <= '0;
            for (int i = 0; i < int'(N_BANK); i++) begin
                addr_q[i] <= '0;
            end
            we_q    <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rdy_q   <= rdy_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.oDATA       = data_q;
    assign bus.oADDR_WR_0  = addr_q[0];
    assign bus.oADDR_WR_1  = addr_q[1];
    assign bus.oADDR_WR_2  = addr_q[2];
    assign bus.oADDR_WR_3  = addr_q[3];
    assign bus.oWE_0       = we_q[0];
    assign bus.oWE_1       = we_q[1];
    assign bus.oWE_2       = we_q[2];
    assign bus.oWE_3       = we_q[3];
    assign bus.oSTART      = start_q;
    assign bus.oBUSY       = busy_q;
    assign bus.oFRAME_DONE = done_q;
    assign bus.oDROP_CNT   = drop_q;
endmodule

// File: tb/tb_fft_adc_loader.sv
// Directed bench for fft_adc_loader: gapped and continuous frames, drops,
// FFT ready edge detection, abort, async reset and drop-counter saturation.
module tb_fft_adc_loader;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fft_adc_loader_if bus ();

    fft_adc_loader dut (
        .iCLK  (clk),
        .iRESET(rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] we4();
        return 32'({bus.oWE_3, bus.oWE_2, bus.oWE_1, bus.oWE_0});
    endfunction

    function automatic logic [31:0] addr_of(input int b);
        case (b)
            0:       return 32'(bus.oADDR_WR_0);
            1:       return 32'(bus.oADDR_WR_1);
            2:       return 32'(bus.oADDR_WR_2);
            default: return 32'(bus.oADDR_WR_3);
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(bus.oDATA), 32'd0);
        for (int b = 0; b < 4; b++) check({tag, "_addr"}, addr_of(b), 32'd0);
        check({tag, "_we"}, we4(), 32'd0);
        check({tag, "_start"}, 32'(bus.oSTART), 32'd0);
        check({tag, "_busy"}, 32'(bus.oBUSY), 32'd0);
        check({tag, "_done"}, 32'(bus.oFRAME_DONE), 32'd0);
        check({tag, "_drop"}, 32'(bus.oDROP_CNT), 32'd0);
    endtask

    // Presents sample idx and checks its write one cycle later
    task automatic send(input int idx, input logic [15:0] d);
        int b;
        bus.iVALID  = 1'b1;
        bus.iSAMPLE = d;
        step();
        b = idx / 512;
        check("wr_we", we4(), 32'(1 << b));
        check("wr_addr", addr_of(b), 32'(idx % 512));
        check("wr_data", 32'(bus.oDATA), 32'(d));
        check("wr_start", 32'(bus.oSTART), 32'(idx == 2047));
        check("wr_busy", 32'(bus.oBUSY), 32'(idx == 2047));
    endtask

    task automatic gap();
        bus.iVALID = 1'b0;
        step();
        check("gap_we", we4(), 32'd0);
        check("gap_start", 32'(bus.oSTART), 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.iENABLE  = 1'b0;
        bus.iVALID   = 1'b0;
        bus.iSAMPLE  = '0;
        bus.iFFT_RDY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        // Gapped frame: valid 1,0,1,0
        bus.iENABLE = 1'b1;
        step();
        check("idle_we", we4(), 32'd0);
        for (int i = 0; i < 2048; i++) begin
            send(i, 16'(i * 3 + 5));
            if (i != 2047) gap();
        end
        bus.iVALID = 1'b0;
        step();
        check("g_start_off", 32'(bus.oSTART), 32'd0);
        check("g_busy_wait", 32'(bus.oBUSY), 32'd1);
        check("g_drop", 32'(bus.oDROP_CNT), 32'd0);
        bus.iFFT_RDY = 1'b1;
        step();
        check("g_done", 32'(bus.oFRAME_DONE), 32'd1);
        check("g_busy_off", 32'(bus.oBUSY), 32'd0);

        // Continuous frame, value = index; RDY stays high across start
        for (int i = 0; i < 2048; i++) begin
            send(i, 16'(i));
            if (i == 0) check("c_done_clr", 32'(bus.oFRAME_DONE), 32'd0);
        end
        bus.iVALID = 1'b0;
        step();
        check("c_start_once", 32'(bus.oSTART), 32'd0);
        for (int k = 0; k < 100; k++) begin
            bus.iVALID  = 1'b1;
            bus.iSAMPLE = 16'(k);
            step();
            check("drop_we", we4(), 32'd0);
            check("drop_busy", 32'(bus.oBUSY), 32'd1);
            check("drop_nodone", 32'(bus.oFRAME_DONE), 32'd0);
        end
        check("drop_cnt100", 32'(bus.oDROP_CNT), 32'd100);
        bus.iVALID   = 1'b0;
        bus.iFFT_RDY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rdy_low_done", 32'(bus.oFRAME_DONE), 32'd0);
            check("rdy_low_busy", 32'(bus.oBUSY), 32'd1);
        end
        bus.iFFT_RDY = 1'b1;
        step();
        check("rdy_edge_done", 32'(bus.oFRAME_DONE), 32'd1);
        check("rdy_edge_busy", 32'(bus.oBUSY), 32'd0);
        check("rdy_edge_drop", 32'(bus.oDROP_CNT), 32'd100);

        // Next frame starts at bank 0 address 0, then abort after 700 samples
        send(0, 16'h1234);
        for (int i = 1; i < 700; i++) send(i, 16'(16'h8000 + i));
        bus.iENABLE = 1'b0;
        bus.iVALID  = 1'b1;
        bus.iSAMPLE = 16'hDEAD;
        step();
        check("abort_we", we4(), 32'd0);
        check("abort_start", 32'(bus.oSTART), 32'd0);
        check("abort_data", 32'(bus.oDATA), 32'(16'h82BB));
        bus.iENABLE = 1'b1;
        step();
        check("reen_idle_we", we4(), 32'd0);
        for (int i = 0; i < 10; i++) send(i, 16'(16'hBEE0 + i));

        // Asynchronous reset between clock edges
        bus.iVALID = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        @(negedge clk);
        rst = 1'b0;
        step();
        check("arst_idle_we", we4(), 32'd0);

        // Saturation run: full frame then a long WAIT with valid held high
        bus.iFFT_RDY = 1'b0;
        for (int i = 0; i < 2048; i++) send(i, 16'(i) ^ 16'h5A5A);
        bus.iVALID  = 1'b1;
        bus.iENABLE = 1'b0;
        for (int k = 0; k < 65540; k++) step();
        check("sat_drop", 32'(bus.oDROP_CNT), 32'd65535);
        check("sat_busy", 32'(bus.oBUSY), 32'd1);
        bus.iFFT_RDY = 1'b1;
        step();
        check("sat_done", 32'(bus.oFRAME_DONE), 32'd1);
        check("sat_busy_off", 32'(bus.oBUSY), 32'd0);
        step();
        check("sat_idle_we", we4(), 32'd0);
        check("sat_drop_hold", 32'(bus.oDROP_CNT), 32'd65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_adc_loader.md
# fft_adc_loader

Front-end sample loader for `fft_top`. It takes a stream of signed 16-bit ADC samples and writes one 2048-point frame into the FFT input RAM: four banks of 512 words each. When the last sample is written, it pulses the FFT start strobe. It then holds off new frames until the FFT reports completion. It sits directly upstream of `fft_top` and drives its `iDATA`, `iADDR_WR_k`, `iWE_k` and `iSTART` inputs.

## Interface
Parameters:
- `DATA_W`, 16: sample width.
- `BANK_AW`, 9: per-bank address width (512 words).
- `N_BANK`, 4: number of banks. Fixed at 4; the ports below are explicit per bank.

Ports:
- `iCLK`  in  1: single clock. All logic is on its rising edge.
- `iRESET`  in  1: reset, asynchronous, active-high.
- `iENABLE`  in  1: level. Allows frames to be captured.
- `iSAMPLE`  in  16: signed ADC sample.
- `iVALID`  in  1: `iSAMPLE` is valid this cycle. There is no backpressure.
- `iFFT_RDY`  in  1: `oRDY` from `fft_top`.
- `oDATA`  out  16: write data to the FFT RAM.
- `oADDR_WR_0` … `oADDR_WR_3`  out  9 each: per-bank write address.
- `oWE_0` … `oWE_3`  out  1 each: per-bank write enable. At most one is high in any cycle.
- `oSTART`  out  1: one-cycle pulse to `fft_top.iSTART`.
- `oBUSY`  out  1: high in the START and WAIT states.
- `oFRAME_DONE`  out  1: one-cycle pulse when the FFT completes a frame.
- `oDROP_CNT`  out  16: count of samples dropped while busy. Saturates at 65535.

## Operation
- States: IDLE, FILL, START, WAIT.
- IDLE:
  - `iVALID` is ignored and not counted as a drop.
  - `iENABLE`=1 → FILL, with sample counter n=0.
- FILL:
  - Each cycle with `iVALID`=1 accepts one sample at index n (11 bits).
  - Bank = n[10:9], address = n[8:0]. Bank 0 receives samples 0..511, bank 1 receives 512..1023, and so on.
  - n increments by 1 per accepted sample.
  - Acceptance of n=2047 → START.
  - `iENABLE`=0 in FILL → IDLE and n cleared. The partial frame is abandoned and no `oSTART` is issued. Words already written stay in RAM. The sample in that cycle is not written.
- START:
  - Lasts exactly one cycle; `oSTART`=1.
  - `iVALID` is dropped.
  - → WAIT.
- WAIT:
  - Every `iVALID`=1 increments `oDROP_CNT` (saturating).
  - Completion is a rising edge of `iFFT_RDY`: the registered previous value is 0 and the current value is 1. A level already high on entry does not count.
  - On completion: `oFRAME_DONE`=1 for one cycle, then → FILL if `iENABLE`=1, else → IDLE. The completion cycle's `iVALID` is dropped.
- `oDROP_CNT` clears only on reset.
- `iENABLE` changes during START or WAIT have no effect until completion.

## Timing
- Reset values: `oDATA`=0, all `oADDR_WR_k`=0, all `oWE_k`=0, `oSTART`=0, `oBUSY`=0, `oFRAME_DONE`=0, `oDROP_CNT`=0. State=IDLE, n=0, registered `iFFT_RDY`=0.
- Write path latency is 1 cycle. A sample accepted at edge T appears at T+1 as:
  - `oDATA` = the sample,
  - `oADDR_WR_b` = n[8:0],
  - `oWE_b`=1 for exactly that cycle.
- Non-selected `oADDR_WR_k` hold their last value. `oDATA` holds its value when no write occurs.
- Sample 2047 accepted at edge T: its write is visible at T+1 and `oSTART`=1 during T+1. The RAM write commits at the end of T+1 and `fft_top` samples `oSTART` at that same edge.
- `oBUSY` is high from T+1 through the cycle in which the `iFFT_RDY` rising edge is detected, inclusive.
- Back-to-back frames: the first FILL sample can be accepted in the cycle after `oFRAME_DONE`.
- Minimum frame time at continuous `iVALID` is 2048 cycles from first acceptance to `oSTART`.
- An asserted `iRESET` mid-frame or mid-WAIT immediately forces all outputs to their reset values. An `oSTART` pulse in progress is cut off.

## Test plan
- **Frame fill.** Stimulus: reset, `iENABLE`=1, 2048 consecutive valid samples with value = index. Required:
  - `oWE_0` is high at addresses 0..511 with data 0..511, then banks 1, 2, 3 in turn.
  - Exactly one `oWE_k` is high per write cycle.
  - `oSTART` pulses once, in the same cycle as the sample-2047 write (bank 3, address 511).
- **Gapped input.** Stimulus: `iVALID` toggling 1,0,1,0 through a full frame. Required: 2048 writes, addresses contiguous, `oSTART` in the cycle of the last write, `oDROP_CNT`=0.
- **Drops while busy.** Stimulus: after `oSTART`, 100 valid samples before `iFFT_RDY` rises. Required: `oDROP_CNT`=100, no `oWE_k` asserted, `oBUSY`=1 throughout.
- **RDY edge detect.** Stimulus: `iFFT_RDY` held 1 across `oSTART`, then dropped to 0 for 5 cycles, then raised. Required: `oFRAME_DONE` pulses only after the 0→1 edge; the next frame starts filling at bank 0, address 0.
- **Abort.** Stimulus: `iENABLE` dropped after 700 samples, then re-enabled. Required: no `oSTART`; the next write goes to bank 0, address 0.
- **Async reset.** Stimulus: `iRESET` pulsed mid-FILL, off the clock edge. Required: all outputs 0 immediately, state IDLE; `oDROP_CNT` saturates at 65535 in a separate long-WAIT run.
